complex_diff_pipe: RTL and testbench



---
 rtl/complex_pkg.sv | 46 ++++
 rtl/pipe_stage.sv | 36 +++
 rtl/complex_diff_pipe.sv | 71 +++++++
 tb/tb_complex_diff_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_pkg.sv
// Shared types and scaling helpers for the complex butterfly datapath.
// COMPLEX_DIFF_ROUND_EN adds round-half-up scaling with saturation.
package complex_pkg;

  localparam int DATA_WIDTH = 16;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } cplx_t;

  // Halving drops the LSB of the DATA_WIDTH+1 difference (arithmetic shift right by 1).
  function automatic cplx_t cplx_half_trunc(input logic signed [DATA_WIDTH:0] d_re,
                                            input logic signed [DATA_WIDTH:0] d_im);
    cplx_t r;
    r.re = d_re[DATA_WIDTH:1];
    r.im = d_im[DATA_WIDTH:1];
    return r;
  endfunction

`ifdef COMPLEX_DIFF_ROUND_EN
  localparam logic signed [DATA_WIDTH+1:0] RND_ONE = 1;
  localparam logic signed [DATA_WIDTH+1:0] SAT_MAX = (2 ** (DATA_WIDTH - 1)) - 1;
  localparam logic signed [DATA_WIDTH+1:0] SAT_MIN = -(2 ** (DATA_WIDTH - 1));

  function automatic logic signed [DATA_WIDTH-1:0] half_round_sat(
      input logic signed [DATA_WIDTH:0] d);
    logic signed [DATA_WIDTH+1:0] r;
    r = {d[DATA_WIDTH], d};
    r = r + RND_ONE;
    r = r >>> 1;
    if (r > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    else if (r < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else return r[DATA_WIDTH-1:0];
  endfunction

  function automatic cplx_t cplx_half_round(input logic signed [DATA_WIDTH:0] d_re,
                                            input logic signed [DATA_WIDTH:0] d_im);
    cplx_t r;
    r.re = half_round_sat(d_re);
    r.im = half_round_sat(d_im);
    return r;
  endfunction
`endif

endpackage

// File: rtl/pipe_stage.sv
// One-entry valid/data pipeline register: loads when empty or when its
// current contents advance downstream in the same cycle.
module pipe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_load) r_valid <= 1'b1;
      else if (i_ready) r_valid <= 1'b0;
      if (w_load) r_data <= i_data;
    end
  end

endmodule

// File: rtl/complex_diff_pipe.sv
// Two-stage flow-controlled complex subtractor: out = (A - B) / 2.
// COMPLEX_DIFF_ROUND_EN selects round-half-up with saturation instead of truncation.
module complex_diff_pipe
  import complex_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] Re_1,
  input  logic [DataWidth-1:0] Im_1,
  input  logic [DataWidth-1:0] Re_2,
  input  logic [DataWidth-1:0] Im_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] Re_out,
  output logic [DataWidth-1:0] Im_out
);

  logic signed [DataWidth:0]       w_d_re_p0;
  logic signed [DataWidth:0]       w_d_im_p0;
  logic                            vld_p1;
  logic                            w_s2_ready;
  logic [2*(DataWidth+1)-1:0]      w_s1_data_p1;
  logic signed [DataWidth:0]       w_d_re_p1;
  logic signed [DataWidth:0]       w_d_im_p1;
  cplx_t                           w_half_p1;
  logic [2*DataWidth-1:0]          w_s2_data_p2;

  // Stage 0 -> 1: full-precision differences, operands sign-extended by one bit
  assign w_d_re_p0 = {Re_1[DataWidth-1], Re_1} - {Re_2[DataWidth-1], Re_2};
  assign w_d_im_p0 = {Im_1[DataWidth-1], Im_1} - {Im_2[DataWidth-1], Im_2};

  pipe_stage #(.W(2 * (DataWidth + 1))) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  ({w_d_re_p0, w_d_im_p0}),
    .o_valid (vld_p1),
    .o_data  (w_s1_data_p1),
    .i_ready (w_s2_ready)
  );

  // Stage 1 -> 2: scale by 1/2 into the shared butterfly Q-format
  assign w_d_re_p1 = w_s1_data_p1[2*(DataWidth+1)-1 -: DataWidth+1];
  assign w_d_im_p1 = w_s1_data_p1[DataWidth:0];

`ifdef COMPLEX_DIFF_ROUND_EN
  assign w_half_p1 = cplx_half_round(w_d_re_p1, w_d_im_p1);
`else
  assign w_half_p1 = cplx_half_trunc(w_d_re_p1, w_d_im_p1);
`endif

  pipe_stage #(.W(2 * DataWidth)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (vld_p1),
    .o_ready (w_s2_ready),
    .i_data  (w_half_p1),
    .o_valid (out_valid),
    .o_data  (w_s2_data_p2),
    .i_ready (out_ready)
  );

  assign Re_out = w_s2_data_p2[2*DataWidth-1 -: DataWidth];
  assign Im_out = w_s2_data_p2[DataWidth-1:0];

endmodule

// File: tb/tb_complex_diff_pipe.sv
// Directed self-checking bench for complex_diff_pipe (both scaling builds).
module tb_complex_diff_pipe;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DW-1:0] Re_1 = '0, Im_1 = '0, Re_2 = '0, Im_2 = '0;
  logic [DW-1:0] Re_out, Im_out;

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  logic [2*DW-1:0] got_q[$];

  always #5 clk = ~clk;

  complex_diff_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Re_1      (Re_1),
    .Im_1      (Im_1),
    .Re_2      (Re_2),
    .Im_2      (Im_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Re_out    (Re_out),
    .Im_out    (Im_out)
  );

  // Record each output transfer mid-cycle, ahead of the edge that completes it
  always @(negedge clk)
    if (mon_en && rst_n && out_valid && out_ready) got_q.push_back({Re_out, Im_out});

  function automatic int floor_half(input int x);
    return (x >= 0) ? x / 2 : -((-x + 1) / 2);
  endfunction

  function automatic int half_model(input int d);
    int r;
`ifdef COMPLEX_DIFF_ROUND_EN
    r = floor_half(d + 1);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`else
    r = floor_half(d);
`endif
    return r;
  endfunction

  function automatic logic [2*DW-1:0] model(input int are, input int aim, input int bre, input int bim);
    logic [DW-1:0] hr, hi;
    hr = DW'(half_model(are - bre));
    hi = DW'(half_model(aim - bim));
    return {hr, hi};
  endfunction

  task automatic drive(input int are, input int aim, input int bre, input int bim);
    Re_1 = DW'(are);
    Im_1 = DW'(aim);
    Re_2 = DW'(bre);
    Im_2 = DW'(bim);
  endtask

  // One pair through an idle pipe; samples out_valid after each of the next three edges
  task automatic run_single(input int are, input int aim, input int bre, input int bim,
                            output logic v0, output logic v1, output logic v2,
                            output int ore, output int oim);
    drive(are, aim, bre, bim);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    v0 = out_valid;
    in_valid = 1'b0;
    @(posedge clk); #1;
    v1 = out_valid;
    ore = int'($signed(Re_out));
    oim = int'($signed(Im_out));
    @(posedge clk); #1;
    v2 = out_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (Re_out !== '0 || Im_out !== '0) begin bad++; $display("FAIL reset_data got=(%0d,%0d) want=(0,0)", Re_out, Im_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_basic;
    logic v0, v1, v2;
    int ore, oim;
    run_single(100, -50, 40, 10, v0, v1, v2, ore, oim);
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", v0); end
    total++; if (v1 !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", v1); end
    total++; if (ore !== 30 || oim !== -30) begin bad++; $display("FAIL basic_data got=(%0d,%0d) want=(30,-30)", ore, oim); end
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b want=0", v2); end
  endtask

  task automatic test_extremes;
    logic v0, v1, v2;
    int ore, oim, wre, wim;
`ifdef COMPLEX_DIFF_ROUND_EN
    wre = 32767; wim = -32767;
`else
    wre = 32767; wim = -32768;
`endif
    run_single(32767, -32768, -32768, 32767, v0, v1, v2, ore, oim);
    total++; if (v1 !== 1'b1) begin bad++; $display("FAIL extremes_valid got=%b want=1", v1); end
    total++; if (ore !== wre || oim !== wim) begin bad++; $display("FAIL extremes_data got=(%0d,%0d) want=(%0d,%0d)", ore, oim, wre, wim); end
  endtask

  task automatic test_round_sign;
    logic v0, v1, v2;
    int ore, oim, wre, wim;
`ifdef COMPLEX_DIFF_ROUND_EN
    wre = 2; wim = -1;
`else
    wre = 1; wim = -2;
`endif
    run_single(3, -3, 0, 0, v0, v1, v2, ore, oim);
    total++; if (v1 !== 1'b1) begin bad++; $display("FAIL round_sign_valid got=%b want=1", v1); end
    total++; if (ore !== wre || oim !== wim) begin bad++; $display("FAIL round_sign_data got=(%0d,%0d) want=(%0d,%0d)", ore, oim, wre, wim); end
  endtask

  // Vector i: A=(100+20i, -10i), B=(4i, 30) -> out=(50+8i, -5i-15); even differences, same in both builds
  task automatic test_backpressure;
    int idx = 0;
    logic acc, stalled, saw_block = 1'b0;
    logic [2*DW-1:0] held;
    logic [DW-1:0] wre, wim;
    got_q.delete();
    for (int c = 0; c < 40 && got_q.size() < 8; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid = (idx < 8);
      drive(100 + 20 * idx, -10 * idx, 4 * idx, 30);
      #1;
      acc = in_valid && in_ready;
      if (!in_ready) saw_block = 1'b1;
      stalled = out_valid && !out_ready;
      held = {Re_out, Im_out};
      @(posedge clk); #1;
      if (acc) idx++;
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || {Re_out, Im_out} !== held) begin
          bad++; $display("FAIL bp_hold cycle=%0d got=%b/%h want=1/%h", c, out_valid, {Re_out, Im_out}, held);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++; if (saw_block !== 1'b1) begin bad++; $display("FAIL bp_in_ready_drop got=%b want=1", saw_block); end
    total++; if (idx !== 8) begin bad++; $display("FAIL bp_accepted got=%0d want=8", idx); end
    total++; if (got_q.size() !== 8) begin bad++; $display("FAIL bp_count got=%0d want=8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      wre = DW'(50 + 8 * i);
      wim = DW'(-5 * i - 15);
      total++;
      if (got_q[i] !== {wre, wim}) begin bad++; $display("FAIL bp_data idx=%0d got=%h want=%h", i, got_q[i], {wre, wim}); end
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [2*DW-1:0] exp_q[$];
    int ar, ai, br, bi;
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ar = int'($urandom_range(65535)) - 32768;
      ai = int'($urandom_range(65535)) - 32768;
      br = int'($urandom_range(65535)) - 32768;
      bi = int'($urandom_range(65535)) - 32768;
      drive(ar, ai, br, bi);
      in_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready idx=%0d got=%b want=1", i, in_ready); end
      exp_q.push_back(model(ar, ai, br, bi));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (got_q.size() !== 62) begin bad++; $display("FAIL b2b_rate got=%0d want=62", got_q.size()); end
    repeat (3) @(posedge clk); #1;
    total++; if (got_q.size() !== 64) begin bad++; $display("FAIL b2b_count got=%0d want=64", got_q.size()); end
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_data idx=%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic v0, v1, v2;
    int ore, oim;
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(500, 500, 100, 100);
    @(posedge clk); #1;
    drive(600, 600, 100, 100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b%b want=10", out_valid, in_ready); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
    total++; if (Re_out !== '0 || Im_out !== '0) begin bad++; $display("FAIL rmid_data got=(%0d,%0d) want=(0,0)", Re_out, Im_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    repeat (4) @(posedge clk); #1;
    total++; if (got_q.size() !== 0 || out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale got=%0d/%b want=0/0", got_q.size(), out_valid); end
    run_single(7, 1, 1, 5, v0, v1, v2, ore, oim);
    total++; if (v1 !== 1'b1 || ore !== 3 || oim !== -2) begin bad++; $display("FAIL rmid_after got=%b(%0d,%0d) want=1(3,-2)", v1, ore, oim); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_round_sign();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
